// File: rtl/matmul_pkg.sv
// Shared state encoding and width helpers for the matrix-multiply sequencer.
package matmul_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ISSUE    = 3'd1,
      DRAIN    = 3'd2,
      OUTPUT   = 3'd3,
      DONE     = 3'd4,
      WAIT_CLR = 3'd5
   } ctrl_state_t;

   localparam int RD_LAT = 1;

   // Width needed to index 0..n-1, never narrower than one bit.
   function automatic int bits_for(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int k_bits(input int maxk);
      return bits_for(maxk + 1);
   endfunction

   function automatic int a_addr_bits(input int m, input int maxk);
      return bits_for(m * maxk);
   endfunction

   function automatic int b_addr_bits(input int maxk, input int n);
      return bits_for(maxk * n);
   endfunction

endpackage

// File: rtl/matmul_compute_ctrl_delay.sv
// Resettable W-bit shift register of DEPTH stages used to align control with
// the memory read latency and the MAC drain.
module ctrl_delay_line #(
   parameter int W     = 1,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage_r [DEPTH];

   // Shift chain, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < DEPTH; s++) stage_r[s] <= {W{1'b0}};
      end else begin
         stage_r[0] <= d;
         for (int s = 1; s < DEPTH; s++) stage_r[s] <= stage_r[s-1];
      end
   end

   assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/matmul_compute_ctrl.sv
// Sequencer for C = A*B: walks C row-major, issues A/B reads, steers the MAC.
// Optional `MATMUL_CTRL_PERF_EN adds busy_cycles / stall_cycles counters.
module matmul_compute_ctrl
   import matmul_pkg::*;
#(
   parameter int INW     = 12,
   parameter int M       = 7,
   parameter int N       = 9,
   parameter int MAXK    = 8,
   parameter int MAC_LAT = 1,
   localparam int K_BITS      = k_bits(MAXK),
   localparam int A_ADDR_BITS = a_addr_bits(M, MAXK),
   localparam int B_ADDR_BITS = b_addr_bits(MAXK, N),
   localparam int ROW_BITS    = bits_for(M),
   localparam int COL_BITS    = bits_for(N)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   matrices_loaded,
   input  logic [K_BITS-1:0]      K,
   output logic [A_ADDR_BITS-1:0] A_read_addr,
   output logic [B_ADDR_BITS-1:0] B_read_addr,
   output logic                   mac_valid,
   output logic                   mac_init,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ROW_BITS-1:0]    out_row,
   output logic [COL_BITS-1:0]    out_col,
   output logic                   compute_finished
`ifdef MATMUL_CTRL_PERF_EN
   ,
   output logic [31:0]            busy_cycles,
   output logic [31:0]            stall_cycles
`endif
);

   // Operand width only sizes the external datapath; nothing here depends on it.
   if (INW < 1) begin : g_inw_guard
   end

   ctrl_state_t            state_r, state_s;
   logic [K_BITS-1:0]      kr_r, k_r;
   logic [ROW_BITS-1:0]    i_r, i_s;
   logic [COL_BITS-1:0]    j_r, j_s;
   logic [A_ADDR_BITS-1:0] rowbase_r, rowbase_s, a_addr_r;
   logic [B_ADDR_BITS-1:0] b_addr_r;
   logic                   out_valid_r, done_r;
   logic                   issue_s, first_k_s, last_k_s, last_col_s, last_row_s;
   logic                   drain_last_s;
   logic [1:0]             mac_ctrl_s;

   assign issue_s    = (state_r == ISSUE);
   assign first_k_s  = (k_r == {K_BITS{1'b0}});
   assign last_k_s   = (k_r == kr_r - K_BITS'(1'b1));
   assign last_col_s = (j_r == COL_BITS'(N - 1));
   assign last_row_s = (i_r == ROW_BITS'(M - 1));

   ctrl_delay_line #(.W(2), .DEPTH(RD_LAT)) u_mac_pipe (
      .clk   (clk),
      .reset (reset),
      .d     ({issue_s, issue_s & first_k_s}),
      .q     (mac_ctrl_s)
   );

   // The last-term flag reaches the drain check once the accumulator has settled.
   ctrl_delay_line #(.W(1), .DEPTH(RD_LAT + MAC_LAT)) u_drain_pipe (
      .clk   (clk),
      .reset (reset),
      .d     (issue_s & last_k_s),
      .q     (drain_last_s)
   );

   // Next state and next element indices.
   always_comb begin
      state_s   = state_r;
      i_s       = i_r;
      j_s       = j_r;
      rowbase_s = rowbase_r;
      case (state_r)
         IDLE: begin
            if (matrices_loaded) begin
               i_s       = {ROW_BITS{1'b0}};
               j_s       = {COL_BITS{1'b0}};
               rowbase_s = {A_ADDR_BITS{1'b0}};
               state_s   = (K == {K_BITS{1'b0}}) ? DONE : ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE:  state_s = last_k_s ? DRAIN : ISSUE;
         DRAIN:  state_s = drain_last_s ? OUTPUT : DRAIN;
         OUTPUT: begin
            if (out_ready) begin
               if (!last_col_s) begin
                  j_s     = j_r + COL_BITS'(1'b1);
                  state_s = ISSUE;
               end else if (!last_row_s) begin
                  j_s       = {COL_BITS{1'b0}};
                  i_s       = i_r + ROW_BITS'(1'b1);
                  rowbase_s = rowbase_r + A_ADDR_BITS'(kr_r);
                  state_s   = ISSUE;
               end else begin
                  j_s       = {COL_BITS{1'b0}};
                  i_s       = {ROW_BITS{1'b0}};
                  rowbase_s = {A_ADDR_BITS{1'b0}};
                  state_s   = DONE;
               end
            end else begin
               state_s = OUTPUT;
            end
         end
         DONE:     state_s = WAIT_CLR;
         WAIT_CLR: state_s = matrices_loaded ? WAIT_CLR : IDLE;
         default:  state_s = IDLE;
      endcase
   end

   // State, counters and registered outputs; addresses are zero outside ISSUE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         kr_r        <= {K_BITS{1'b0}};
         k_r         <= {K_BITS{1'b0}};
         i_r         <= {ROW_BITS{1'b0}};
         j_r         <= {COL_BITS{1'b0}};
         rowbase_r   <= {A_ADDR_BITS{1'b0}};
         a_addr_r    <= {A_ADDR_BITS{1'b0}};
         b_addr_r    <= {B_ADDR_BITS{1'b0}};
         out_valid_r <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r   <= state_s;
         i_r       <= i_s;
         j_r       <= j_s;
         rowbase_r <= rowbase_s;
         if (state_r == IDLE && matrices_loaded) kr_r <= K;
         k_r <= (issue_s && state_s == ISSUE) ? k_r + K_BITS'(1'b1) : {K_BITS{1'b0}};
         if (state_s != ISSUE) begin
            a_addr_r <= {A_ADDR_BITS{1'b0}};
            b_addr_r <= {B_ADDR_BITS{1'b0}};
         end else if (issue_s) begin
            a_addr_r <= a_addr_r + A_ADDR_BITS'(1'b1);
            b_addr_r <= b_addr_r + B_ADDR_BITS'(N);
         end else begin
            a_addr_r <= rowbase_s;
            b_addr_r <= B_ADDR_BITS'(j_s);
         end
         out_valid_r <= (state_s == OUTPUT);
         done_r      <= (state_s == DONE);
      end
   end

   assign A_read_addr      = a_addr_r;
   assign B_read_addr      = b_addr_r;
   assign mac_valid        = mac_ctrl_s[1];
   assign mac_init         = mac_ctrl_s[0];
   assign out_valid        = out_valid_r;
   assign out_row          = i_r;
   assign out_col          = j_r;
   assign compute_finished = done_r;

`ifdef MATMUL_CTRL_PERF_EN
   logic [31:0] busy_r, stall_r;

   // Saturating run counters, cleared when a run starts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_r  <= 32'd0;
         stall_r <= 32'd0;
      end else if (state_r == IDLE && matrices_loaded) begin
         busy_r  <= 32'd0;
         stall_r <= 32'd0;
      end else begin
         if (state_r != IDLE && state_r != WAIT_CLR && busy_r != 32'hFFFF_FFFF)
            busy_r <= busy_r + 32'd1;
         if (out_valid_r && !out_ready && stall_r != 32'hFFFF_FFFF)
            stall_r <= stall_r + 32'd1;
      end
   end

   assign busy_cycles  = busy_r;
   assign stall_cycles = stall_r;
`endif

endmodule

// File: tb/tb_matmul_compute_ctrl.sv
// Scoreboard bench for matmul_compute_ctrl: a 2x2 instance with hand values and
// the default 7x9 instance driven against a small memory/MAC model.
module tb_matmul_compute_ctrl;

   localparam int M = 7;
   localparam int N = 9;

   logic clk = 1'b0;
   logic reset;

   logic       ml, mv, mi, ov, ordy, cf;
   logic [3:0] k_in;
   logic [5:0] a_addr;
   logic [6:0] b_addr;
   logic [2:0] orow;
   logic [3:0] ocol;

   logic       ml2, mv2, mi2, ov2, ordy2, cf2;
   logic [3:0] k2, a2, b2;
   logic       orow2, ocol2;

   typedef struct {
      int row;
      int col;
      int val;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp2_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int a_mem[64];
   int b_mem[128];
   int a_mem2[16];
   int b_mem2[16];
   int a_q, b_q, acc, a_q2, b_q2, acc2;
   int cf_cnt = 0, cf2_cnt = 0, mv_cnt = 0, ov_cnt = 0, mv2_cnt = 0;
   int max_a = 0, max_b = 0;
   int init_cnt = 0, cur_elem = -1;
   int prev_a = 0, prev_b = 0, prev_row = 0, prev_col = 0;
   bit prev_stall = 1'b0;
   bit log_en = 1'b0;
   int a_log[$], b_log[$], i_log[$];

   always #5 clk = ~clk;

   matmul_compute_ctrl u_dut (
      .clk              (clk),
      .reset            (reset),
      .matrices_loaded  (ml),
      .K                (k_in),
      .A_read_addr      (a_addr),
      .B_read_addr      (b_addr),
      .mac_valid        (mv),
      .mac_init         (mi),
      .out_valid        (ov),
      .out_ready        (ordy),
      .out_row          (orow),
      .out_col          (ocol),
      .compute_finished (cf)
   );

   matmul_compute_ctrl #(.M(2), .N(2)) u_dut2 (
      .clk              (clk),
      .reset            (reset),
      .matrices_loaded  (ml2),
      .K                (k2),
      .A_read_addr      (a2),
      .B_read_addr      (b2),
      .mac_valid        (mv2),
      .mac_init         (mi2),
      .out_valid        (ov2),
      .out_ready        (ordy2),
      .out_row          (orow2),
      .out_col          (ocol2),
      .compute_finished (cf2)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int r, input int c, input int v);
      exp_t e;
      e.row = r;
      e.col = c;
      e.val = v;
      return e;
   endfunction

   function automatic int cref(input int i, input int j, input int kk);
      int s = 0;
      for (int t = 0; t < kk; t++) s += a_mem[i*kk + t] * b_mem[t*N + j];
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cf1(input string name, input int budget);
      int start = cf_cnt;
      int n = 0;
      while (cf_cnt == start && n < budget) begin
         tick();
         n++;
      end
      if (cf_cnt == start) check(name, 0, 1);
   endtask

   task automatic wait_cf2(input string name, input int budget);
      int start = cf2_cnt;
      int n = 0;
      while (cf2_cnt == start && n < budget) begin
         tick();
         n++;
      end
      if (cf2_cnt == start) check(name, 0, 1);
   endtask

   // Synchronous-read memories and a MAC with one-cycle result latency.
   always @(posedge clk) begin
      a_q  <= a_mem[a_addr];
      b_q  <= b_mem[b_addr];
      if (mv) acc <= mi ? a_q * b_q : acc + a_q * b_q;
      a_q2 <= a_mem2[a2];
      b_q2 <= b_mem2[b2];
      if (mv2) acc2 <= mi2 ? a_q2 * b_q2 : acc2 + a_q2 * b_q2;
   end

   // Monitor for the 7x9 instance: scoreboard, stall rules, address log.
   always @(negedge clk) begin
      exp_t e;
      if (cf) cf_cnt++;
      if (mv) mv_cnt++;
      if (ov) ov_cnt++;
      if (a_addr > max_a) max_a = a_addr;
      if (b_addr > max_b) max_b = b_addr;
      if (mv && mi) begin
         cur_elem = init_cnt;
         init_cnt++;
      end
      if (mv && log_en && cur_elem == 11) begin
         a_log.push_back(prev_a);
         b_log.push_back(prev_b);
         i_log.push_back(mi);
      end
      if (cf) init_cnt = 0;
      if (ov) begin
         if (prev_stall) begin
            check("stall_row_stable", orow, prev_row);
            check("stall_col_stable", ocol, prev_col);
         end
         if (!ordy) check("stall_quiet", {mv, a_addr, b_addr}, 0);
         if (ordy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_row", orow, e.row);
               check("out_col", ocol, e.col);
               check("out_value", acc, e.val);
            end
         end
      end
      prev_stall = ov && !ordy;
      prev_row   = orow;
      prev_col   = ocol;
      prev_a     = a_addr;
      prev_b     = b_addr;
   end

   // Monitor for the 2x2 instance.
   always @(negedge clk) begin
      exp_t e;
      if (cf2) cf2_cnt++;
      if (mv2) mv2_cnt++;
      if (ov2 && ordy2) begin
         if (exp2_q.size() == 0) begin
            check("unexpected_out_2x2", 1, 0);
         end else begin
            e = exp2_q.pop_front();
            check("out_row_2x2", orow2, e.row);
            check("out_col_2x2", ocol2, e.col);
            check("out_value_2x2", acc2, e.val);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, hold, c0, m0, o0;
      int ea[3];
      int eb[3];
      int ei[3];
      ea = '{3, 4, 5};
      eb = '{2, 11, 20};
      ei = '{1, 0, 0};
      for (int x = 0; x < 64; x++) a_mem[x] = (x * 7 + 3) % 16;
      for (int x = 0; x < 128; x++) b_mem[x] = (x * 5 + 1) % 16;
      for (int x = 0; x < 16; x++) begin
         a_mem2[x] = 0;
         b_mem2[x] = 0;
      end
      a_mem2[0] = 1; a_mem2[1] = 2; a_mem2[2] = 3; a_mem2[3] = 4;
      b_mem2[0] = 5; b_mem2[1] = 6; b_mem2[2] = 7; b_mem2[3] = 8;

      reset = 1'b1; ml = 1'b0; k_in = 4'd0; ordy = 1'b0;
      ml2 = 1'b0; k2 = 4'd0; ordy2 = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("reset_state", {mv, mi, ov, cf, a_addr, b_addr, orow, ocol}, 0);
      check("reset_state_2x2", {mv2, mi2, ov2, cf2, a2, b2, orow2, ocol2}, 0);

      // 2x2 problem, always ready.
      exp2_q.push_back(mk(0, 0, 19));
      exp2_q.push_back(mk(0, 1, 22));
      exp2_q.push_back(mk(1, 0, 43));
      exp2_q.push_back(mk(1, 1, 50));
      k2 = 4'd2; ordy2 = 1'b1; ml2 = 1'b1;
      wait_cf2("finish_timeout_2x2", 200);
      repeat (3) tick();
      check("cf_pulses_2x2", cf2_cnt, 1);
      check("drained_2x2", exp2_q.size(), 0);
      check("mac_valid_count_2x2", mv2_cnt, 8);
      ml2 = 1'b0;

      // 7x9 with K=3: stall at (0,0), log element (1,2).
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++) exp_q.push_back(mk(i, j, cref(i, j, 3)));
      log_en = 1'b1; k_in = 4'd3; ordy = 1'b0; ml = 1'b1;
      m0 = mv_cnt;
      n = 0;
      while (!ov && n < 100) begin
         tick();
         n++;
      end
      check("first_out_latency", n, 6);
      hold = 0;
      repeat (5) begin
         if (ov) hold++;
         tick();
      end
      ordy = 1'b1;
      if (ov) hold++;
      tick();
      check("hold_cycles", hold, 6);
      check("released_after_accept", ov, 0);
      wait_cf1("finish_timeout_k3", 1500);
      log_en = 1'b0;
      check("mac_valid_count_k3", mv_cnt - m0, M * N * 3);
      check("drained_k3", exp_q.size(), 0);
      check("elem12_len", a_log.size(), 3);
      for (int t = 0; t < 3 && t < a_log.size(); t++) begin
         check("elem12_a_addr", a_log[t], ea[t]);
         check("elem12_b_addr", b_log[t], eb[t]);
         check("elem12_mac_init", i_log[t], ei[t]);
      end

      // No rerun while matrices_loaded stays high.
      c0 = cf_cnt; m0 = mv_cnt; o0 = ov_cnt;
      repeat (10) tick();
      check("no_rerun_cf", cf_cnt - c0, 0);
      check("no_rerun_mac", mv_cnt - m0, 0);
      check("no_rerun_out", ov_cnt - o0, 0);
      ml = 1'b0;
      repeat (2) tick();

      // K=0 load: straight to compute_finished.
      k_in = 4'd0; ml = 1'b1;
      c0 = cf_cnt; m0 = mv_cnt; o0 = ov_cnt;
      n = 0;
      while (cf_cnt == c0 && n < 4) begin
         tick();
         n++;
      end
      check("k0_cf_latency", n, 2);
      repeat (5) tick();
      check("k0_cf_pulses", cf_cnt - c0, 1);
      check("k0_no_mac", mv_cnt - m0, 0);
      check("k0_no_out", ov_cnt - o0, 0);
      ml = 1'b0;
      repeat (2) tick();

      // K=MAXK run aborted by an asynchronous reset, then rerun to completion.
      check("queue_empty_before_abort", exp_q.size(), 0);
      k_in = 4'd8; ml = 1'b1;
      repeat (3) tick();
      check("pre_reset_a_addr", a_addr, 2);
      check("pre_reset_mac_valid", mv, 1);
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_outputs", {mv, mi, ov, cf, a_addr, b_addr, orow, ocol}, 0);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++) exp_q.push_back(mk(i, j, cref(i, j, 8)));
      repeat (2) tick();
      reset = 1'b0;
      c0 = cf_cnt;
      wait_cf1("finish_timeout_k8", 1500);
      repeat (3) tick();
      check("k8_cf_pulses", cf_cnt - c0, 1);
      check("drained_k8", exp_q.size(), 0);
      check("max_a_addr", max_a, 55);
      check("max_b_addr", max_b, 71);
      ml = 1'b0;
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
